// File: rtl/ecc_checker.sv
`default_nettype none
// ============================================================================
// Module   : ecc_checker
// Brief    : Two-stage parity/format checker for 72-bit codewords, with a
//            saturating error counter. The optional first-error capture is
//            enabled by the macro ECC_CHECKER_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_checker #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr,
    output logic             cap_valid,
    output logic [71:0]      cap_word,
    output logic [31:0]      cap_index
);

`ifdef ECC_CHECKER_CAPTURE_EN
    localparam int c_WORD_W = 72;
`else
    localparam int c_WORD_W = 64;
`endif
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                r_rdy_en;
    logic                r_s1_valid;
    logic                r_s1_err;
    logic [c_WORD_W-1:0] r_s1_word;
    logic                r_out_valid;
    logic                r_out_err;
    logic [63:0]         r_out_data;
    logic [CNT_W-1:0]    r_err_count;

    logic w_in_err;
    logic w_s2_free;
    logic w_s1_adv;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_err   = (^in_data[63:0] != in_data[64]) || (in_data[71:65] != 7'd0);
    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    // r_rdy_en holds in_ready low until the first clock after reset release.
    assign in_ready   = r_rdy_en && (!r_s1_valid || w_s2_free);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rdy_en   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_word  <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_err   <= w_in_err;
                r_s1_word  <= in_data[c_WORD_W-1:0];
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_out_err   <= r_s1_err;
            r_out_data  <= r_s1_word[63:0];
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_out_xfer && r_out_err && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

`ifdef ECC_CHECKER_CAPTURE_EN
    logic [7:0]  r_s2_tag;
    logic [31:0] r_word_idx;
    logic        r_cap_valid;
    logic [71:0] r_cap_word;
    logic [31:0] r_cap_index;

    // Upper codeword bits travel alongside stage 2 so the capture sees the full word.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s2_tag <= '0;
        end else if (w_s1_adv) begin
            r_s2_tag <= r_s1_word[71:64];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_word_idx  <= '0;
            r_cap_valid <= 1'b0;
            r_cap_word  <= '0;
            r_cap_index <= '0;
        end else begin
            if (w_out_xfer) begin
                r_word_idx <= r_word_idx + 32'd1;
            end
            if (err_clr) begin
                r_cap_valid <= 1'b0;
            end else if (w_out_xfer && r_out_err && !r_cap_valid) begin
                r_cap_valid <= 1'b1;
                r_cap_word  <= {r_s2_tag, r_out_data};
                r_cap_index <= r_word_idx;
            end
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_word  = r_cap_word;
    assign cap_index = r_cap_index;
`else
    assign cap_valid = 1'b0;
    assign cap_word  = '0;
    assign cap_index = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_checker
// Brief    : Randomised and directed bench for ecc_checker against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_checker;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = 15;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [71:0]         in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [63:0]         out_data;
    logic                out_err;
    logic [TB_CNT_W-1:0] err_count;
    logic                err_clr = 1'b0;
    logic                cap_valid;
    logic [71:0]         cap_word;
    logic [31:0]         cap_index;

    ecc_checker #(.CNT_W(TB_CNT_W)) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_count (err_count),
        .err_clr   (err_clr),
        .cap_valid (cap_valid),
        .cap_word  (cap_word),
        .cap_index (cap_index)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [71:0] word;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_cnt;
    logic [31:0] m_idx;
    logic        m_capv;
    logic [71:0] m_capw;
    logic [31:0] m_capi;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [71:0] w);
        return (^w[63:0] != w[64]) || (w[71:65] != 7'd0);
    endfunction

    function automatic logic [71:0] good_word(input logic [63:0] d);
        return {7'd0, ^d, d};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_idx  = '0;
        m_capv = 1'b0;
        m_capw = '0;
        m_capi = '0;
    endtask

    task automatic check_state();
        chk("err_count", {68'd0, err_count}, m_cnt);
`ifdef ECC_CHECKER_CAPTURE_EN
        chk("cap_valid", cap_valid, m_capv);
        chk("cap_word",  cap_word,  m_capw);
        chk("cap_index", cap_index, m_capi);
`else
        chk("cap_valid_tied", cap_valid, 0);
        chk("cap_word_tied",  cap_word,  0);
        chk("cap_index_tied", cap_index, 0);
`endif
    endtask

    // One clock: drive, predict the handshakes, then check registered state.
    task automatic step(input logic v, input logic [71:0] d, input logic ordy, input logic clr);
        logic        do_in, do_out, held, he;
        logic [63:0] hd;
        exp_t        e;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        do_in  = in_valid && in_ready;
        do_out = out_valid && out_ready;
        held   = out_valid && !out_ready;
        hd     = out_data;
        he     = out_err;
        e      = '0;
        if (do_out) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.word[63:0]);
                chk("out_err",  out_err,  e.err);
            end
        end
        if (clr) begin
            m_cnt  = 0;
            m_capv = 1'b0;
        end else if (do_out && e.err) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!m_capv) begin
                m_capv = 1'b1;
                m_capw = e.word;
                m_capi = m_idx;
            end
        end
        if (do_out) m_idx = m_idx + 32'd1;
        if (do_in) sb.push_back({d, ref_err(d)});
        @(posedge sys_clk);
        #1;
        if (held) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data",  out_data,  hd);
            chk("hold_err",   out_err,   he);
        end
        check_state();
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_err",   out_err,   0);
        chk("rst_err_count", err_count, 0);
        chk("rst_cap_valid", cap_valid, 0);
        chk("rst_cap_word",  cap_word,  0);
        chk("rst_cap_index", cap_index, 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready, 0);
        @(posedge sys_clk);
        #1;
        chk("rel_in_ready_high", in_ready, 1);
    endtask

    logic [71:0] w;
    logic [71:0] words[8];

    initial begin
        model_reset();
        @(posedge sys_clk);
        #1;
        do_reset();

        // Latency of a single clean zero word.
        step(1'b1, 72'd0, 1'b1, 1'b0);
        chk("lat_cycle1_valid", out_valid, 0);
        step(1'b0, 72'd0, 1'b1, 1'b0);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_data", out_data, 0);
        chk("lat_err",  out_err,  0);
        drain();
        chk("lat_err_count", err_count, 0);

        // Eight back-to-back words, word 3 with a flipped parity bit.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            words[i] = good_word({$urandom, $urandom});
            if (i == 3) words[i][64] = ~words[i][64];
        end
        for (int i = 0; i < 8; i++) begin
            chk("stream_in_ready", in_ready, 1);
            step(1'b1, words[i], 1'b1, 1'b0);
        end
        drain();
        chk("stream_err_count", err_count, 1);
`ifdef ECC_CHECKER_CAPTURE_EN
        chk("stream_cap_index", cap_index, 3);
        chk("stream_cap_word",  cap_word,  words[3]);
`else
        chk("stream_cap_index", cap_index, 0);
        chk("stream_cap_word",  cap_word,  0);
`endif

        // Backpressure: five stalled cycles with a full pipeline.
        for (int i = 0; i < 8; i++) begin
            w = good_word({$urandom, $urandom});
            step(1'b1, w, (i < 2 || i > 6), 1'b0);
            if (i == 4) chk("stall_in_ready", in_ready, 0);
        end
        drain();

        // Saturation at 15, then clear coinciding with an errored transfer.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            w = good_word({$urandom, $urandom});
            w[71] = 1'b1;
            step(1'b1, w, 1'b1, 1'b0);
        end
        drain();
        chk("sat_err_count", err_count, CNT_MAX);
        w = good_word({$urandom, $urandom});
        w[64] = ~w[64];
        step(1'b1, w, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("clr_pre_valid", out_valid, 1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("clr_err_count", err_count, 0);
        chk("clr_cap_valid", cap_valid, 0);

        // Reset with two words in flight.
        step(1'b1, good_word({$urandom, $urandom}), 1'b0, 1'b0);
        step(1'b1, good_word({$urandom, $urandom}), 1'b0, 1'b0);
        chk("inflight_valid", out_valid, 1);
        #2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("post_rst_no_stale", out_valid, 0);
        end

        // Randomised traffic with errors, backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            w = good_word({$urandom, $urandom});
            case ($urandom_range(0, 7))
                0: w[64] = ~w[64];
                1: w[$urandom_range(65, 71)] = 1'b1;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
